uart: RTL and testbench
=======================

UART -- requirements
Module: uart

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, line bit rate in bit/s.
REQ-003 SHALL have parameter DATA_WIDTH, default 8, data bits per frame and AXI-Stream tdata width.
REQ-004 SHALL have port clk, input, 1, the single clock for all logic (rising edge).
REQ-005 SHALL have port rst, input, 1, reset: one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port s_axis_tdata, input, DATA_WIDTH, byte to transmit.
REQ-007 SHALL have port s_axis_tvalid, input, 1, transmit data valid.
REQ-008 SHALL have port s_axis_tready, output, 1, transmitter can accept a word.
REQ-009 SHALL have port m_axis_tdata, output, DATA_WIDTH, received word.
REQ-010 SHALL have port m_axis_tvalid, output, 1, received word valid.
REQ-011 SHALL have port m_axis_tready, input, 1, downstream accepts received word.
REQ-012 SHALL have port rx_wire, input, 1, serial receive line, asynchronous to clk, idle high.
REQ-013 SHALL have port tx_wire, output, 1, serial transmit line, idle high.

Function
REQ-014 SHALL use bit period BIT_CYC = CLK_FREQ/BAUD_RATE clocks (integer division; 434 at defaults); half period = BIT_CYC/2.
REQ-015 SHALL use frame format: 1 start bit (0), DATA_WIDTH data bits LSB first, optional parity (REQ-028), 1 stop bit (1).
REQ-016 TX SHALL be an FSM with states IDLE, START, DATA, STOP (PARITY when enabled); each non-IDLE state lasts exactly BIT_CYC clocks.
REQ-017 s_axis_tready SHALL be 1 only in TX IDLE; a transfer occurs on a clock edge with tvalid&&tready, which latches tdata and enters START.
REQ-018 tx_wire SHALL go low on the clock after the handshake, and s_axis_tready SHALL be 0 from that clock until the full stop bit has elapsed.
REQ-019 With tvalid held high, back-to-back frames SHALL be separated by at most one idle clock; tx_wire SHALL be registered (glitch-free).
REQ-020 RX SHALL pass rx_wire through a 2-flop synchronizer; only the synchronized signal is used.
REQ-021 RX FSM (IDLE, START, DATA, STOP, PARITY when enabled) SHALL leave IDLE on a synchronized 1->0 edge.
REQ-022 RX SHALL resample the start bit at half period; if it is 1, return to IDLE (glitch rejection), else sample each further bit at BIT_CYC intervals (mid-bit).
REQ-023 At the mid-stop sample, a 1 SHALL produce a valid word; a 0 (framing error) SHALL discard the word; RX returns to IDLE either way, ready for the next start edge.
REQ-024 On a valid word, m_axis_tdata SHALL be loaded and m_axis_tvalid set on the clock after the mid-stop sample; tdata holds stable while tvalid=1.
REQ-025 m_axis_tvalid SHALL clear on the clock edge with tvalid&&tready, unless a new word is loaded on the same edge, in which case it stays 1 with new data.
REQ-026 If a new word completes while m_axis_tvalid=1 and m_axis_tready=0 (overrun), the new word SHALL be dropped and the held word kept.

Reset
REQ-027 While rst=0: both FSMs in IDLE, counters and shift registers 0, tx_wire=1, s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, synchronizer flops=1; a frame in progress is abandoned; s_axis_tready rises on the first clock after release.

Configuration
REQ-028 Macro UART_PARITY_EN SHALL, when defined, add an even-parity bit (XOR of data bits) after the last data bit on TX, and RX SHALL check it, discarding the word on mismatch; when undefined, frames carry no parity bit and no parity logic exists.

Verification
REQ-029 Reset release, s_axis_tvalid=1, tdata=0x00 -> tready drops next clock; tx_wire low 434 clocks, then 8 x 434 clocks low, then 434 clocks high.
REQ-030 Loopback tx_wire->rx_wire, m_axis_tready=1, source sends 0x00,0x01,0x02,... on each handshake -> m_axis_tdata sequence 0x00,0x01,0x02,... with no gaps or duplicates.
REQ-031 Send 0xA5 -> tx_wire data bits 1,0,1,0,0,1,0,1 (LSB first); RX loopback delivers 0xA5 one clock after mid-stop sample.
REQ-032 rx_wire low pulse of 100 clocks then high -> no m_axis_tvalid, RX returns to IDLE.
REQ-033 Frame 0x3C with stop bit forced 0 -> no word delivered; following correct frame 0x55 -> delivered 0x55.
REQ-034 m_axis_tready=0, two frames 0x11 then 0x22 received -> m_axis_tdata stays 0x11 with tvalid=1; after tready=1 for one clock, tvalid=0.

Source files
------------

// File: rtl/uart.sv
// ----------------------------------------------------------------------------
// uart: AXI-Stream UART with 2-flop RX synchronizer and registered TX line.
// Optional even parity when UART_PARITY_EN is defined.   Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  input  logic                  rx_wire,
  output logic                  tx_wire
);

  localparam int BIT_CYC  = CLK_FREQ / BAUD_RATE;
  localparam int HALF_CYC = BIT_CYC / 2;
  localparam int CNT_W    = $clog2(BIT_CYC);
  localparam int IDX_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(DATA_WIDTH - 1);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;
`else
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
`endif

  // ---------------------------------------------------------------- TX
  tx_state_e             tx_state_q, tx_state_d;
  logic [CNT_W-1:0]      tx_cnt_q, tx_cnt_d;
  logic [IDX_W-1:0]      tx_idx_q, tx_idx_d;
  logic [DATA_WIDTH-1:0] tx_shreg_q, tx_shreg_d;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic                  tx_q, tx_d;
  logic                  tx_rdy_q, tx_rdy_d;
  logic                  tx_bit_end;
`ifdef UART_PARITY_EN
  logic                  tx_par_q, tx_par_d;
`endif

  assign tx_shift      = tx_shreg_q >> 1;
  assign tx_bit_end    = (tx_cnt_q == CNT_BIT_END);
  assign tx_wire       = tx_q;
  assign s_axis_tready = tx_rdy_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shreg_q <= '0;
      tx_q       <= 1'b1;
      tx_rdy_q   <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shreg_q <= tx_shreg_d;
      tx_q       <= tx_d;
      tx_rdy_q   <= tx_rdy_d;
`ifdef UART_PARITY_EN
      tx_par_q   <= tx_par_d;
`endif
    end
  end

  // tx_d is the line value for the state being entered, so the pin is a flop.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_shreg_d = tx_shreg_q;
    tx_d       = tx_q;
    tx_rdy_d   = tx_rdy_q;
`ifdef UART_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        tx_d     = 1'b1;
        tx_rdy_d = 1'b1;
        if (s_axis_tvalid && tx_rdy_q) begin
          tx_state_d = TX_START;
          tx_shreg_d = s_axis_tdata;
          tx_idx_d   = '0;
          tx_d       = 1'b0;
          tx_rdy_d   = 1'b0;
`ifdef UART_PARITY_EN
          tx_par_d   = ^s_axis_tdata;
`endif
        end
      end
      TX_START: begin
        tx_cnt_d = tx_cnt_q + 1'b1;
        if (tx_bit_end) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_DATA;
          tx_d       = tx_shreg_q[0];
        end
      end
      TX_DATA: begin
        tx_cnt_d = tx_cnt_q + 1'b1;
        if (tx_bit_end) begin
          tx_cnt_d = '0;
          if (tx_idx_q == IDX_LAST) begin
`ifdef UART_PARITY_EN
            tx_state_d = TX_PARITY;
            tx_d       = tx_par_q;
`else
            tx_state_d = TX_STOP;
            tx_d       = 1'b1;
`endif
          end else begin
            tx_idx_d   = tx_idx_q + 1'b1;
            tx_shreg_d = tx_shift;
            tx_d       = tx_shift[0];
          end
        end
      end
`ifdef UART_PARITY_EN
      TX_PARITY: begin
        tx_cnt_d = tx_cnt_q + 1'b1;
        if (tx_bit_end) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_STOP;
          tx_d       = 1'b1;
        end
      end
`endif
      TX_STOP: begin
        tx_cnt_d = tx_cnt_q + 1'b1;
        if (tx_bit_end) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_IDLE;
          tx_rdy_d   = 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- RX
  logic                  rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e             rx_state_q, rx_state_d;
  logic [CNT_W-1:0]      rx_cnt_q, rx_cnt_d;
  logic [IDX_W-1:0]      rx_idx_q, rx_idx_d;
  logic [DATA_WIDTH-1:0] rx_shreg_q, rx_shreg_d;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic                  rx_bit_end;
  logic                  rx_word_ok;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  m_valid_q, m_valid_d;
`ifdef UART_PARITY_EN
  logic                  rx_par_err_q, rx_par_err_d;
`endif

  assign rx_shift      = DATA_WIDTH'({rx_sync_q, rx_shreg_q} >> 1);
  assign rx_bit_end    = (rx_cnt_q == CNT_BIT_END);
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tvalid = m_valid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shreg_q <= '0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_err_q <= 1'b0;
`endif
    end else begin
      rx_meta_q  <= rx_wire;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shreg_q <= rx_shreg_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
`ifdef UART_PARITY_EN
      rx_par_err_q <= rx_par_err_d;
`endif
    end
  end

  // Counting restarts on the detected edge, so each sample lands mid-bit.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_shreg_d = rx_shreg_q;
    rx_word_ok = 1'b0;
`ifdef UART_PARITY_EN
    rx_par_err_d = rx_par_err_q;
`endif
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
      end
      RX_START: begin
        rx_cnt_d = rx_cnt_q + 1'b1;
        if (rx_cnt_q == CNT_HALF_END) begin
          rx_cnt_d   = '0;
          rx_idx_d   = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        rx_cnt_d = rx_cnt_q + 1'b1;
        if (rx_bit_end) begin
          rx_cnt_d   = '0;
          rx_shreg_d = rx_shift;
          if (rx_idx_q == IDX_LAST) begin
`ifdef UART_PARITY_EN
            rx_state_d = RX_PARITY;
`else
            rx_state_d = RX_STOP;
`endif
          end else begin
            rx_idx_d = rx_idx_q + 1'b1;
          end
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: begin
        rx_cnt_d = rx_cnt_q + 1'b1;
        if (rx_bit_end) begin
          rx_cnt_d     = '0;
          rx_par_err_d = rx_sync_q ^ (^rx_shreg_q);
          rx_state_d   = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        rx_cnt_d = rx_cnt_q + 1'b1;
        if (rx_bit_end) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
`ifdef UART_PARITY_EN
          rx_word_ok = rx_sync_q && !rx_par_err_q;
`else
          rx_word_ok = rx_sync_q;
`endif
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // A word arriving while the held one is not being taken is dropped.
  always_comb begin
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    if (rx_word_ok && (!m_valid_q || m_axis_tready)) begin
      m_data_d  = rx_shreg_q;
      m_valid_d = 1'b1;
    end else if (m_valid_q && m_axis_tready) begin
      m_valid_d = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart.sv
// ----------------------------------------------------------------------------
// tb_uart: self-checking bench for uart (default build, no parity).
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_uart;
  localparam int CLK_FREQ = 50_000_000;
  localparam int BAUD     = 115200;
  localparam int BC       = CLK_FREQ / BAUD;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] s_axis_tdata = 8'h00;
  logic       s_axis_tvalid = 1'b0;
  logic       s_axis_tready;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready = 1'b1;
  logic       tx_wire;
  logic       rx_drv = 1'b1;
  logic       lb_en = 1'b0;
  wire        rx_line = lb_en ? tx_wire : rx_drv;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  uart #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .DATA_WIDTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .rx_wire      (rx_line),
    .tx_wire      (tx_wire)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Receive-side observer: accepted words and tvalid rising edges.
  logic [7:0] rxq[$];
  int   rise_cyc = 0;
  int   rise_cnt = 0;
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    if (m_axis_tvalid && m_axis_tready) rxq.push_back(m_axis_tdata);
    if (m_axis_tvalid && !prev_v) begin
      rise_cyc <= cyc;
      rise_cnt <= rise_cnt + 1;
    end
    prev_v <= m_axis_tvalid;
  end

  initial begin
    #900000;
    $display("FAIL watchdog sim_time=%0t limit=900000", $time);
    $fatal(1, "watchdog");
  end

  // Offer one byte; h returns the cycle number of the handshake edge.
  task automatic send_byte(input logic [7:0] b, output int h);
    int t;
    s_axis_tdata  = b;
    s_axis_tvalid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!s_axis_tready && t < 20000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (!s_axis_tready) begin
      errors++;
      $display("FAIL send_timeout tready=%b required=1", s_axis_tready);
    end
    h = cyc + 1;
    @(posedge clk);
    #1 s_axis_tvalid = 1'b0;
  endtask

  // Sample tx_wire at the middle of each of the 10 bit cells after a handshake.
  task automatic capture_frame(output logic [9:0] bits);
    repeat (BC / 2) @(posedge clk);
    #1 bits[0] = tx_wire;
    for (int k = 1; k < 10; k++) begin
      repeat (BC) @(posedge clk);
      #1 bits[k] = tx_wire;
    end
  endtask

  // Drive one serial frame on rx_drv followed by one bit time of idle.
  task automatic drive_frame(input logic [7:0] b, input logic stop);
    @(posedge clk);
    #1 rx_drv = 1'b0;
    repeat (BC) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx_drv = b[i];
      repeat (BC) @(posedge clk);
    end
    #1 rx_drv = stop;
    repeat (BC) @(posedge clk);
    #1 rx_drv = 1'b1;
    repeat (BC) @(posedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++; if (tx_wire !== 1'b1) begin errors++; $display("FAIL rst_tx got=%b exp=1", tx_wire); end
    checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL rst_tready got=%b exp=0", s_axis_tready); end
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_mvalid got=%b exp=0", m_axis_tvalid); end
    checks++; if (m_axis_tdata !== 8'h00) begin errors++; $display("FAIL rst_mdata got=%h exp=00", m_axis_tdata); end
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL rel_tready_early got=%b exp=0", s_axis_tready); end
    @(negedge clk);
    checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL rel_tready got=%b exp=1", s_axis_tready); end
  endtask

  task automatic test_tx_zero;
    int lowc, highc;
    logic rdy_bad;
    @(posedge clk);
    #1 rst = 1'b0;
    s_axis_tdata  = 8'h00;
    s_axis_tvalid = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL zero_tready_up got=%b exp=1", s_axis_tready); end
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    checks++; if (s_axis_tready !== 1'b0 || tx_wire !== 1'b0) begin
      errors++; $display("FAIL zero_start tready=%b tx=%b exp tready=0 tx=0", s_axis_tready, tx_wire);
    end
    lowc = 0; rdy_bad = 1'b0;
    while (tx_wire === 1'b0 && lowc < 5000) begin
      if (s_axis_tready) rdy_bad = 1'b1;
      lowc++;
      @(negedge clk);
    end
    highc = 0;
    while (tx_wire === 1'b1 && !s_axis_tready && highc < 1000) begin
      highc++;
      @(negedge clk);
    end
    checks++; if (lowc != 9 * BC) begin errors++; $display("FAIL zero_low_len got=%0d exp=%0d", lowc, 9 * BC); end
    checks++; if (highc != BC) begin errors++; $display("FAIL zero_stop_len got=%0d exp=%0d", highc, BC); end
    checks++; if (rdy_bad !== 1'b0) begin errors++; $display("FAIL zero_tready_busy got=%b exp=0", rdy_bad); end
  endtask

  task automatic test_loopback;
    int hs[4];
    int n, t;
    lb_en = 1'b1;
    m_axis_tready = 1'b1;
    repeat (20) @(posedge clk);
    rxq.delete();
    #1 s_axis_tdata = 8'h00;
    s_axis_tvalid = 1'b1;
    n = 0; t = 0;
    while (n < 4 && t < 30000) begin
      @(negedge clk);
      t++;
      if (s_axis_tready) begin
        hs[n] = cyc + 1;
        n++;
        @(posedge clk);
        #1 s_axis_tdata = 8'(n);
        if (n == 4) s_axis_tvalid = 1'b0;
      end
    end
    s_axis_tvalid = 1'b0;
    checks++; if (n != 4) begin errors++; $display("FAIL lb_handshakes got=%0d exp=4", n); end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (hs[i] - hs[i-1] < 10 * BC || hs[i] - hs[i-1] > 10 * BC + 1) begin
        errors++; $display("FAIL lb_gap%0d got=%0d exp=%0d..%0d", i, hs[i] - hs[i-1], 10 * BC, 10 * BC + 1);
      end
    end
    t = 0;
    while (rxq.size() < 4 && t < 6000) begin @(posedge clk); t++; end
    repeat (50) @(posedge clk);
    checks++; if (rxq.size() != 4) begin errors++; $display("FAIL lb_count got=%0d exp=4", rxq.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= rxq.size() || rxq[i] !== 8'(i)) begin
        errors++; $display("FAIL lb_word%0d got=%h exp=%h", i, (i < rxq.size()) ? rxq[i] : 8'hxx, 8'(i));
      end
    end
  endtask

  task automatic test_random_tx;
    logic [7:0] sent[2];
    logic [9:0] bits, expf;
    int h, t;
    lb_en = 1'b1;
    m_axis_tready = 1'b1;
    rxq.delete();
    for (int i = 0; i < 2; i++) begin
      sent[i] = 8'($urandom);
      expf = {1'b1, sent[i], 1'b0};
      send_byte(sent[i], h);
      capture_frame(bits);
      checks++;
      if (bits !== expf) begin errors++; $display("FAIL rnd_bits%0d got=%b exp=%b", i, bits, expf); end
      t = 0;
      while (rxq.size() <= i && t < 200) begin @(posedge clk); t++; end
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= rxq.size() || rxq[i] !== sent[i]) begin
        errors++; $display("FAIL rnd_word%0d got=%h exp=%h", i, (i < rxq.size()) ? rxq[i] : 8'hxx, sent[i]);
      end
    end
  endtask

  task automatic test_a5;
    logic [7:0] b;
    logic [9:0] bits;
    int h, t, rc0, mid_stop;
    b = 8'hA5;
    lb_en = 1'b1;
    m_axis_tready = 1'b1;
    rxq.delete();
    rc0 = rise_cnt;
    send_byte(b, h);
    capture_frame(bits);
    checks++; if (bits[0] !== 1'b0) begin errors++; $display("FAIL a5_start got=%b exp=0", bits[0]); end
    for (int k = 1; k <= 8; k++) begin
      checks++;
      if (bits[k] !== ((b >> (k - 1)) & 8'h01) != 0) begin
        errors++; $display("FAIL a5_bit%0d got=%b exp=%0d", k - 1, bits[k], (b >> (k - 1)) & 8'h01);
      end
    end
    checks++; if (bits[9] !== 1'b1) begin errors++; $display("FAIL a5_stop got=%b exp=1", bits[9]); end
    t = 0;
    while (rise_cnt == rc0 && t < 200) begin @(posedge clk); t++; end
    @(negedge clk);
    mid_stop = 9 * BC + BC / 2;
    checks++;
    if (rise_cnt == rc0 || rise_cyc - h < mid_stop || rise_cyc - h > mid_stop + 6) begin
      errors++; $display("FAIL a5_latency got=%0d exp=%0d..%0d", rise_cyc - h, mid_stop, mid_stop + 6);
    end
    checks++;
    if (rxq.size() != 1 || rxq[0] !== b) begin
      errors++; $display("FAIL a5_word got=%h count=%0d exp=a5 count=1", (rxq.size() > 0) ? rxq[0] : 8'hxx, rxq.size());
    end
  endtask

  task automatic test_glitch;
    logic [7:0] b;
    int rc0;
    lb_en = 1'b0;
    rx_drv = 1'b1;
    m_axis_tready = 1'b1;
    repeat (10) @(posedge clk);
    rxq.delete();
    rc0 = rise_cnt;
    #1 rx_drv = 1'b0;
    repeat (100) @(posedge clk);
    #1 rx_drv = 1'b1;
    repeat (1500) @(posedge clk);
    checks++; if (rise_cnt != rc0) begin errors++; $display("FAIL glitch_valid got=%0d exp=0", rise_cnt - rc0); end
    b = 8'($urandom);
    drive_frame(b, 1'b1);
    repeat (10) @(posedge clk);
    checks++;
    if (rxq.size() != 1 || rxq[0] !== b) begin
      errors++; $display("FAIL glitch_recover got=%h count=%0d exp=%h count=1", (rxq.size() > 0) ? rxq[0] : 8'hxx, rxq.size(), b);
    end
  endtask

  task automatic test_framing;
    lb_en = 1'b0;
    m_axis_tready = 1'b1;
    rxq.delete();
    drive_frame(8'h3C, 1'b0);
    checks++; if (rxq.size() != 0) begin errors++; $display("FAIL frame_err_drop got=%0d exp=0", rxq.size()); end
    drive_frame(8'h55, 1'b1);
    repeat (10) @(posedge clk);
    checks++;
    if (rxq.size() != 1 || rxq[0] !== 8'h55) begin
      errors++; $display("FAIL frame_next got=%h count=%0d exp=55 count=1", (rxq.size() > 0) ? rxq[0] : 8'hxx, rxq.size());
    end
  endtask

  task automatic test_overrun;
    lb_en = 1'b0;
    m_axis_tready = 1'b0;
    rxq.delete();
    drive_frame(8'h11, 1'b1);
    drive_frame(8'h22, 1'b1);
    @(negedge clk);
    checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL ovr_valid got=%b exp=1", m_axis_tvalid); end
    checks++; if (m_axis_tdata !== 8'h11) begin errors++; $display("FAIL ovr_hold got=%h exp=11", m_axis_tdata); end
    @(posedge clk);
    #1 m_axis_tready = 1'b1;
    @(posedge clk);
    #1 m_axis_tready = 1'b0;
    @(negedge clk);
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL ovr_clear got=%b exp=0", m_axis_tvalid); end
    checks++;
    if (rxq.size() != 1 || rxq[0] !== 8'h11) begin
      errors++; $display("FAIL ovr_taken got=%h count=%0d exp=11 count=1", (rxq.size() > 0) ? rxq[0] : 8'hxx, rxq.size());
    end
    m_axis_tready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_tx_zero();
    test_loopback();
    test_random_tx();
    test_a5();
    test_glitch();
    test_framing();
    test_overrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
